// File: rtl/lm_sm_reg_sequencer_if.sv
// Handshake bundle between the LM/SM control FSM and the register sequencer.
// Carries start/abort/advance, the register list and the address stream.
interface lm_sm_reg_sequencer_if #(
  parameter int N_REGS = 8,
  parameter int ADDR_W = 3
);
  logic              start;
  logic              abort;
  logic [N_REGS-1:0] reg_list;
  logic              advance;
  logic [ADDR_W-1:0] reg_addr;
  logic              valid;
  logic              last;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;

  modport master (
    output start,
    output abort,
    output reg_list,
    output advance,
    input  reg_addr,
    input  valid,
    input  last,
    input  count,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  abort,
    input  reg_list,
    input  advance,
    output reg_addr,
    output valid,
    output last,
    output count,
    output busy,
    output done
  );
endinterface

// File: rtl/lm_sm_reg_sequencer.sv
// Register-address sequencer for load/store-multiple instructions.
// Define LMSM_DESCEND_EN to walk the list highest index first.
module lm_sm_reg_sequencer #(
  parameter int N_REGS = 8,
  parameter int ADDR_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  lm_sm_reg_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t            state;
  logic [N_REGS-1:0] pending;
  logic [ADDR_W-1:0] reg_addr_q;
  logic              valid_q;
  logic              last_q;
  logic [ADDR_W:0]   count_q;
  logic              busy_q;
  logic              done_q;

  logic [N_REGS-1:0] cur_bit;
  logic [N_REGS-1:0] nxt_pending;

  function automatic logic [ADDR_W-1:0] pick(
    input logic [N_REGS-1:0] m
  );
    logic [ADDR_W-1:0] r;
    r = '0;
`ifdef LMSM_DESCEND_EN
    for (int i = 0; i < N_REGS; i++)
      if (m[i]) r = ADDR_W'(i);
`else
    for (int i = N_REGS - 1; i >= 0; i--)
      if (m[i]) r = ADDR_W'(i);
`endif
    return r;
  endfunction

  function automatic logic single(
    input logic [N_REGS-1:0] m
  );
    return (m != '0) &&
           ((m & (m - N_REGS'(1))) == '0);
  endfunction

  // The bit being offered is always the one named by reg_addr.
  assign cur_bit     = N_REGS'(1) << reg_addr_q;
  assign nxt_pending = pending & ~cur_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= '0;
      reg_addr_q <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (bus.abort) begin
      state   <= IDLE;
      pending <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            pending <= bus.reg_list;
            count_q <= '0;
            busy_q  <= 1'b1;
            if (bus.reg_list != '0) begin
              state      <= RUN;
              valid_q    <= 1'b1;
              reg_addr_q <= pick(bus.reg_list);
              last_q     <= single(bus.reg_list);
            end else begin
              state  <= FIN;
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.advance) begin
            pending <= nxt_pending;
            count_q <= count_q + (ADDR_W+1)'(1);
            if (last_q) begin
              state   <= FIN;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              reg_addr_q <= pick(nxt_pending);
              last_q     <= single(nxt_pending);
            end
          end
        end
        FIN: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.reg_addr = reg_addr_q;
  assign bus.valid    = valid_q;
  assign bus.last     = last_q;
  assign bus.count    = count_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_lm_sm_reg_sequencer.sv
// Scoreboard bench for lm_sm_reg_sequencer.
// Expected transfers/done events are queued; a monitor pops on each event.
module tb_lm_sm_reg_sequencer;
  localparam int N  = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lm_sm_reg_sequencer_if #(.N_REGS(N), .ADDR_W(AW)) bus();

  lm_sm_reg_sequencer #(.N_REGS(N), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit        is_done;
    bit [2:0]  addr;
    bit        last;
    bit [3:0]  cnt;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_x(bit [2:0] a, bit l);
    exp_t e;
    e.is_done = 1'b0; e.addr = a; e.last = l; e.cnt = '0;
    q.push_back(e);
  endtask

  task automatic push_d(bit [3:0] c);
    exp_t e;
    e.is_done = 1'b1; e.addr = '0; e.last = 1'b0; e.cnt = c;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(logic [7:0] l);
    bus.reg_list = l;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  // Monitor: every accepted transfer and every done pulse consumes one entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.valid && bus.advance && !bus.abort) begin
        if (q.size() == 0) chk("xfer_unexpected", 32'(q.size()), 1);
        else begin
          e = q.pop_front();
          chk("xfer_kind", 32'(e.is_done), 0);
          chk("xfer_addr", 32'(bus.reg_addr), 32'(e.addr));
          chk("xfer_last", 32'(bus.last), 32'(e.last));
        end
      end
      if (bus.done) begin
        if (q.size() == 0) chk("done_unexpected", 32'(q.size()), 1);
        else begin
          e = q.pop_front();
          chk("done_kind", 32'(e.is_done), 1);
          chk("done_count", 32'(bus.count), 32'(e.cnt));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  bit [2:0] t1 [4];
  bit [2:0] t4a, t4b, t4c, t5;

  initial begin
`ifdef LMSM_DESCEND_EN
    t1[0] = 3'd7; t1[1] = 3'd5; t1[2] = 3'd2; t1[3] = 3'd0;
    t4a = 3'd7; t4b = 3'd6; t4c = 3'd5; t5 = 3'd5;
`else
    t1[0] = 3'd0; t1[1] = 3'd2; t1[2] = 3'd5; t1[3] = 3'd7;
    t4a = 3'd0; t4b = 3'd1; t4c = 3'd2; t5 = 3'd2;
`endif
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.reg_list = '0; bus.advance = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_outs", {bus.reg_addr, bus.valid, bus.last,
                     bus.count, bus.busy, bus.done}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: sparse list, advance held
    for (int i = 0; i < 4; i++) push_x(t1[i], i == 3);
    push_d(4'd4);
    bus.advance = 1'b1;
    start_seq(8'b1010_0101);
    repeat (4) tick();
    @(negedge clk);
    chk("t1_done", 32'(bus.done), 1);
    chk("t1_count", 32'(bus.count), 4);
    bus.advance = 1'b0;
    tick();
    @(negedge clk);
    chk("t1_idle", {bus.busy, bus.done, bus.valid}, 0);

    // 2: empty list
    push_d(4'd0);
    start_seq(8'h00);
    @(negedge clk);
    chk("t2_done", {bus.done, bus.valid, bus.busy}, 3'b101);
    tick();
    @(negedge clk);
    chk("t2_idle", {bus.done, bus.busy, bus.valid}, 0);

    // 3: single register, stalled consumer
    push_x(3'd7, 1'b1);
    push_d(4'd1);
    start_seq(8'h80);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold", {bus.valid, bus.last, bus.reg_addr,
                      bus.count}, {1'b1, 1'b1, 3'd7, 4'd0});
      tick();
    end
    bus.advance = 1'b1;
    tick();
    bus.advance = 1'b0;
    @(negedge clk);
    chk("t3_done", {bus.done, bus.count}, {1'b1, 4'd1});
    tick();

    // 4: full list, ignored start, abort
    push_x(t4a, 1'b0);
    push_x(t4b, 1'b0);
    start_seq(8'hFF);
    start_seq(8'h10);
    @(negedge clk);
    chk("t4_ign_start", {bus.reg_addr, bus.count}, {t4a, 4'd0});
    bus.advance = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("t4_mid", {bus.reg_addr, bus.count, bus.valid},
        {t4c, 4'd2, 1'b1});
    bus.abort = 1'b1; bus.start = 1'b1; bus.reg_list = 8'h0F;
    tick();
    bus.abort = 1'b0; bus.start = 1'b0; bus.advance = 1'b0;
    @(negedge clk);
    chk("t4_abort", {bus.valid, bus.busy, bus.last, bus.done,
                     bus.count}, {4'b0, 4'd2});
    repeat (3) tick();
    @(negedge clk);
    chk("t4_quiet", {bus.done, bus.busy}, 0);

    // 5: async reset mid-sequence
    push_x(t5, 1'b0);
    bus.advance = 1'b1;
    start_seq(8'h3C);
    tick();
    bus.advance = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst", {bus.reg_addr, bus.valid, bus.last,
                   bus.count, bus.busy, bus.done}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    push_x(3'd0, 1'b1);
    push_d(4'd1);
    bus.advance = 1'b1;
    start_seq(8'h01);
    tick();
    bus.advance = 1'b0;
    @(negedge clk);
    chk("t5_done", 32'(bus.done), 1);
    repeat (3) tick();

    chk("queue_drained", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
